// File: rtl/hash_arbiter.sv
// hash_arbiter: round-robin scheduler that shares one SHA3/SHAKE core among
// NREQ requesters. It latches the winner's mode and input block, drives the
// core's start/acknowledge handshake, and returns the digest on a registered bus.
// Optional build macro HASH_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts a
// stuck job after TIMEOUT_CYCLES cycles and pulses o_err.
module hash_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [2*NREQ-1:0]     i_mode,
    input  logic [272*NREQ-1:0]   i_in,
    output logic [NREQ-1:0]       o_gnt,
    output logic [NREQ-1:0]       o_done,
    output logic [1343:0]         o_out,
    output logic                  o_err,
    output logic [1:0]            o_hash_en,
    output logic [1:0]            o_hash_mode,
    output logic [271:0]          o_hash_in,
    input  logic                  i_hash_done,
    input  logic [1343:0]         i_hash_out
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Reject parameter values the arbitration logic was not built for
    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : gBadParam
        $error("hash_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    typedef enum logic [1:0] {IDLE, START, BUSY, ACK} state_t;

    state_t              state_q;
    logic [IDXW-1:0]     rrPtr_q;
    logic [IDXW-1:0]     grantIdx_q;
    logic [NREQ-1:0]     gnt_q;
    logic [NREQ-1:0]     done_q;
    logic [1:0]          hashEn_q;
    logic [1:0]          hashMode_q;
    logic [271:0]        hashIn_q;
    logic [1343:0]       out_q;

    logic                winFound_d;
    logic [IDXW-1:0]     winIdx_d;
    logic [IDXW:0]       cand_d;
    logic [IDXW-1:0]     candIdx_d;
    logic [NREQ-1:0]     winOneHot_d;
    logic [1:0]          winMode_d;
    logic [271:0]        winIn_d;
    logic [IDXW-1:0]     rrNext_d;

`ifdef HASH_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNTW-1:0]     tmoCnt_q;
    logic                err_q;
`endif

    // Round-robin search: first requester at or above the pointer, wrapping
    always_comb begin
        winFound_d = 1'b0;
        winIdx_d   = '0;
        cand_d     = '0;
        candIdx_d  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_d = {1'b0, rrPtr_q} + (IDXW + 1)'(i);
            if (cand_d >= (IDXW + 1)'(NREQ)) begin
                cand_d = cand_d - (IDXW + 1)'(NREQ);
            end
            candIdx_d = cand_d[IDXW-1:0];
            if (!winFound_d && i_req[candIdx_d]) begin
                winFound_d = 1'b1;
                winIdx_d   = candIdx_d;
            end
        end
    end

    // Select the winner's mode and input block and build its one-hot grant
    always_comb begin
        winOneHot_d = '0;
        winMode_d   = '0;
        winIn_d     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (winIdx_d == IDXW'(k)) begin
                winOneHot_d[k] = 1'b1;
                winMode_d      = i_mode[2*k +: 2];
                winIn_d        = i_in[272*k +: 272];
            end
        end
    end

    assign rrNext_d = (grantIdx_q == IDXW'(NREQ - 1)) ? '0 : grantIdx_q + IDXW'(1);

    // Main sequencer: grant, start pulse, wait for the core, acknowledge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            grantIdx_q <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            hashEn_q   <= 2'b00;
            hashMode_q <= '0;
            hashIn_q   <= '0;
            out_q      <= '0;
`ifdef HASH_ARB_TIMEOUT_EN
            tmoCnt_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            done_q <= '0;
`ifdef HASH_ARB_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (winFound_d) begin
                        gnt_q      <= winOneHot_d;
                        grantIdx_q <= winIdx_d;
                        hashMode_q <= winMode_d;
                        hashIn_q   <= winIn_d;
                        hashEn_q   <= 2'b01;
                        state_q    <= START;
                    end else begin
                        hashEn_q   <= 2'b00;
                    end
                end
                START: begin
                    hashEn_q <= 2'b00;
                    state_q  <= BUSY;
`ifdef HASH_ARB_TIMEOUT_EN
                    tmoCnt_q <= '0;
`endif
                end
                BUSY: begin
                    if (i_hash_done) begin
                        out_q    <= i_hash_out;
                        done_q   <= gnt_q;
                        hashEn_q <= 2'b10;
                        state_q  <= ACK;
                    end
`ifdef HASH_ARB_TIMEOUT_EN
                    else if (tmoCnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
                        err_q    <= 1'b1;
                        hashEn_q <= 2'b10;
                        state_q  <= ACK;
                    end else begin
                        tmoCnt_q <= tmoCnt_q + CNTW'(1);
                    end
`endif
                end
                ACK: begin
                    hashEn_q <= 2'b00;
                    gnt_q    <= '0;
                    rrPtr_q  <= rrNext_d;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_gnt       = gnt_q;
    assign o_done      = done_q;
    assign o_out       = out_q;
    assign o_hash_en   = hashEn_q;
    assign o_hash_mode = hashMode_q;
    assign o_hash_in   = hashIn_q;
`ifdef HASH_ARB_TIMEOUT_EN
    assign o_err       = err_q;
`else
    assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_hash_arbiter.sv
// Directed testbench for hash_arbiter (NREQ=4, TIMEOUT_CYCLES=16). The bench
// plays the hash core itself and checks grant order, handshake timing, latching,
// reset behaviour and, when HASH_ARB_TIMEOUT_EN is defined, the watchdog.
module tb_hash_arbiter;

    localparam int NREQ = 4;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic [NREQ-1:0]      i_req;
    logic [2*NREQ-1:0]    i_mode;
    logic [272*NREQ-1:0]  i_in;
    logic [NREQ-1:0]      o_gnt;
    logic [NREQ-1:0]      o_done;
    logic [1343:0]        o_out;
    logic                 o_err;
    logic [1:0]           o_hash_en;
    logic [1:0]           o_hash_mode;
    logic [271:0]         o_hash_in;
    logic                 i_hash_done;
    logic [1343:0]        i_hash_out;

    int checks   = 0;
    int failures = 0;

    hash_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(16)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_mode      (i_mode),
        .i_in        (i_in),
        .o_gnt       (o_gnt),
        .o_done      (o_done),
        .o_out       (o_out),
        .o_err       (o_err),
        .o_hash_en   (o_hash_en),
        .o_hash_mode (o_hash_mode),
        .o_hash_in   (o_hash_in),
        .i_hash_done (i_hash_done),
        .i_hash_out  (i_hash_out)
    );

    // 100 MHz clock
    always #5 i_clk = ~i_clk;

    // Advance one cycle and land just after the rising edge
    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Distinct 1344-bit digest per seed
    function automatic logic [1343:0] mkDigest(input logic [63:0] seed);
        logic [1343:0] d;
        d = '0;
        for (int k = 0; k < 21; k++) begin
            d[64*k +: 64] = seed ^ (64'h9E37_79B9_7F4A_7C15 * 64'(k + 1));
        end
        return d;
    endfunction

    // Play the core for one job: wait for start, hold done off for 'delay'
    // cycles, then return the digest and capture what the arbiter shows in ACK
    task automatic serveJob(input int delay, input logic [1343:0] digest, input bit perturb,
                            output bit started, output int waitTicks, output logic [3:0] gntSeen,
                            output int zeroCycles, output logic [1:0] modeAtStart, output bit modeStable,
                            output logic [1:0] modeAtAck, output logic [271:0] inAtAck,
                            output logic [1:0] enAtAck, output logic [3:0] doneAtAck,
                            output logic [1343:0] outAtAck);
        started     = 1'b0;
        waitTicks   = 0;
        gntSeen     = '0;
        zeroCycles  = 0;
        modeAtStart = '0;
        modeStable  = 1'b1;
        modeAtAck   = '0;
        inAtAck     = '0;
        enAtAck     = '0;
        doneAtAck   = '0;
        outAtAck    = '0;
        for (int t = 0; t < 64 && !started; t++) begin
            tick();
            waitTicks++;
            if (o_hash_en == 2'b01) started = 1'b1;
        end
        if (!started) return;
        gntSeen     = o_gnt;
        modeAtStart = o_hash_mode;
        for (int c = 0; c < delay; c++) begin
            tick();
            if (o_hash_en == 2'b00) zeroCycles++;
            if (o_hash_mode !== modeAtStart) modeStable = 1'b0;
            if (perturb && c == 0) begin
                i_mode = ~i_mode;
                i_in   = ~i_in;
            end
        end
        i_hash_done = 1'b1;
        i_hash_out  = digest;
        tick();
        i_hash_done = 1'b0;
        i_hash_out  = '0;
        if (o_hash_mode !== modeAtStart) modeStable = 1'b0;
        modeAtAck = o_hash_mode;
        inAtAck   = o_hash_in;
        enAtAck   = o_hash_en;
        doneAtAck = o_done;
        outAtAck  = o_out;
    endtask

    // Shared result holders for serveJob
    bit             jStarted;
    int             jWait;
    logic [3:0]     jGnt;
    int             jZeros;
    logic [1:0]     jModeStart;
    bit             jModeStable;
    logic [1:0]     jModeAck;
    logic [271:0]   jInAck;
    logic [1:0]     jEnAck;
    logic [3:0]     jDoneAck;
    logic [1343:0]  jOutAck;
    logic [1343:0]  lastDigest;

    task automatic test_reset;
        i_req  = 4'b1111;
        i_mode = 8'b00_11_10_01;
        i_rst  = 1'b1;
        tick();
        tick();
        checks++; if (o_gnt !== 4'b0000) begin failures++; $display("[TB] FAIL reset_gnt: got %b expected %b", o_gnt, 4'b0000); end
        checks++; if (o_done !== 4'b0000) begin failures++; $display("[TB] FAIL reset_done: got %b expected %b", o_done, 4'b0000); end
        checks++; if (o_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", o_err); end
        checks++; if (o_hash_en !== 2'b00) begin failures++; $display("[TB] FAIL reset_hash_en: got %b expected 00", o_hash_en); end
        checks++; if (o_hash_mode !== 2'b00) begin failures++; $display("[TB] FAIL reset_hash_mode: got %b expected 00", o_hash_mode); end
        checks++; if (o_hash_in !== 272'd0) begin failures++; $display("[TB] FAIL reset_hash_in: got low %h expected 0", o_hash_in[63:0]); end
        checks++; if (o_out !== 1344'd0) begin failures++; $display("[TB] FAIL reset_out: got low %h expected 0", o_out[127:0]); end
        i_rst = 1'b0;
        tick();
        checks++; if (o_gnt !== 4'b0001) begin failures++; $display("[TB] FAIL reset_first_gnt: got %b expected %b", o_gnt, 4'b0001); end
        checks++; if (o_hash_en !== 2'b01) begin failures++; $display("[TB] FAIL reset_first_start: got %b expected 01", o_hash_en); end
        checks++; if (o_hash_mode !== 2'b01) begin failures++; $display("[TB] FAIL reset_first_mode: got %b expected 01", o_hash_mode); end
        i_req = 4'b0000;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_single_job;
        logic [271:0]  expIn;
        logic [1343:0] dig;
        expIn = {{33{8'h5A}}, 8'hAB};
        dig   = mkDigest(64'h1111_2222_3333_4444);
        i_in[2*272 +: 272] = expIn;
        i_mode = 8'b01_10_11_00;
        i_req  = 4'b0100;
        serveJob(24, dig, 1'b0, jStarted, jWait, jGnt, jZeros, jModeStart, jModeStable, jModeAck, jInAck, jEnAck, jDoneAck, jOutAck);
        checks++; if (!jStarted) begin failures++; $display("[TB] FAIL single_start: got no start expected 01 within 64 cycles"); end
        checks++; if (jGnt !== 4'b0100) begin failures++; $display("[TB] FAIL single_gnt: got %b expected %b", jGnt, 4'b0100); end
        checks++; if (jZeros != 24) begin failures++; $display("[TB] FAIL single_busy_idle_en: got %0d expected 24", jZeros); end
        checks++; if (jModeStart !== 2'b10 || !jModeStable) begin failures++; $display("[TB] FAIL single_mode: got %b stable=%0d expected 10 stable=1", jModeStart, jModeStable); end
        checks++; if (jInAck !== expIn) begin failures++; $display("[TB] FAIL single_hash_in: got low %h expected %h", jInAck[63:0], expIn[63:0]); end
        checks++; if (jEnAck !== 2'b10) begin failures++; $display("[TB] FAIL single_ack_en: got %b expected 10", jEnAck); end
        checks++; if (jDoneAck !== 4'b0100) begin failures++; $display("[TB] FAIL single_done: got %b expected %b", jDoneAck, 4'b0100); end
        checks++; if (jOutAck !== dig) begin failures++; $display("[TB] FAIL single_out: got low %h expected %h", jOutAck[127:0], dig[127:0]); end
        i_req = 4'b0000;
        tick();
        checks++; if (o_done !== 4'b0000) begin failures++; $display("[TB] FAIL single_done_width: got %b expected %b", o_done, 4'b0000); end
        checks++; if (o_gnt !== 4'b0000 || o_hash_en !== 2'b00) begin failures++; $display("[TB] FAIL single_release: got gnt=%b en=%b expected 0000/00", o_gnt, o_hash_en); end
        checks++; if (o_out !== dig) begin failures++; $display("[TB] FAIL single_out_hold: got low %h expected %h", o_out[127:0], dig[127:0]); end
        lastDigest = dig;
    endtask

    task automatic test_fairness;
        logic [3:0]    expOrder [4];
        logic [3:0]    expPair  [3];
        logic [1343:0] dig;
        expOrder = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        expPair  = '{4'b0001, 4'b1000, 4'b0001};
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_req = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            dig = mkDigest(64'(j + 100));
            serveJob(3 + j, dig, 1'b0, jStarted, jWait, jGnt, jZeros, jModeStart, jModeStable, jModeAck, jInAck, jEnAck, jDoneAck, jOutAck);
            checks++; if (jGnt !== expOrder[j] || jDoneAck !== expOrder[j]) begin failures++; $display("[TB] FAIL fair_order%0d: got gnt=%b done=%b expected %b", j, jGnt, jDoneAck, expOrder[j]); end
            i_req = i_req & ~jGnt;
        end
        // One job for requester 0 moves the pointer to 1, then 3 must beat 0
        i_req = 4'b0001;
        for (int j = 0; j < 3; j++) begin
            dig = mkDigest(64'(j + 200));
            serveJob(4, dig, 1'b0, jStarted, jWait, jGnt, jZeros, jModeStart, jModeStable, jModeAck, jInAck, jEnAck, jDoneAck, jOutAck);
            checks++; if (jGnt !== expPair[j]) begin failures++; $display("[TB] FAIL fair_wrap%0d: got %b expected %b", j, jGnt, expPair[j]); end
            i_req = i_req & ~jGnt;
            if (j == 0) i_req = 4'b1001;
        end
        lastDigest = dig;
    endtask

    task automatic test_input_stability;
        logic [1:0]    expMode;
        logic [271:0]  expIn;
        logic [1343:0] dig;
        expMode = i_mode[3:2];
        expIn   = i_in[272 +: 272];
        dig     = mkDigest(64'hCAFE_F00D_0000_0001);
        i_req   = 4'b0010;
        serveJob(10, dig, 1'b1, jStarted, jWait, jGnt, jZeros, jModeStart, jModeStable, jModeAck, jInAck, jEnAck, jDoneAck, jOutAck);
        checks++; if (jGnt !== 4'b0010) begin failures++; $display("[TB] FAIL stab_gnt: got %b expected %b", jGnt, 4'b0010); end
        checks++; if (jModeAck !== expMode || !jModeStable) begin failures++; $display("[TB] FAIL stab_mode: got %b stable=%0d expected %b stable=1", jModeAck, jModeStable, expMode); end
        checks++; if (jInAck !== expIn) begin failures++; $display("[TB] FAIL stab_in: got low %h expected %h", jInAck[63:0], expIn[63:0]); end
        i_req = 4'b0000;
        tick();
        i_hash_done = 1'b1;
        i_hash_out  = mkDigest(64'd99);
        tick();
        tick();
        i_hash_done = 1'b0;
        i_hash_out  = '0;
        checks++; if (o_done !== 4'b0000 || o_gnt !== 4'b0000 || o_hash_en !== 2'b00) begin failures++; $display("[TB] FAIL spurious_done: got done=%b gnt=%b en=%b expected 0000/0000/00", o_done, o_gnt, o_hash_en); end
        checks++; if (o_out !== dig) begin failures++; $display("[TB] FAIL spurious_out: got low %h expected %h", o_out[127:0], dig[127:0]); end
        lastDigest = dig;
    endtask

    task automatic test_back_to_back;
        logic [1343:0] dA;
        logic [1343:0] dB;
        dA    = mkDigest(64'hAAAA);
        dB    = mkDigest(64'hBBBB);
        i_req = 4'b0001;
        serveJob(4, dA, 1'b0, jStarted, jWait, jGnt, jZeros, jModeStart, jModeStable, jModeAck, jInAck, jEnAck, jDoneAck, jOutAck);
        checks++; if (jGnt !== 4'b0001 || jOutAck !== dA) begin failures++; $display("[TB] FAIL b2b_first: got gnt=%b out low %h expected 0001 %h", jGnt, jOutAck[63:0], dA[63:0]); end
        serveJob(4, dB, 1'b0, jStarted, jWait, jGnt, jZeros, jModeStart, jModeStable, jModeAck, jInAck, jEnAck, jDoneAck, jOutAck);
        checks++; if (jWait != 2) begin failures++; $display("[TB] FAIL b2b_gap: got %0d cycles ACK to start expected 2", jWait); end
        checks++; if (jDoneAck !== 4'b0001 || jOutAck !== dB) begin failures++; $display("[TB] FAIL b2b_second: got done=%b out low %h expected 0001 %h", jDoneAck, jOutAck[63:0], dB[63:0]); end
        i_req = 4'b0000;
        tick();
        lastDigest = dB;
    endtask

    task automatic test_reset_mid_job;
        bit            seen;
        logic [1343:0] dR;
        seen  = 1'b0;
        dR    = mkDigest(64'h5EED);
        i_req = 4'b1000;
        for (int t = 0; t < 64 && !seen; t++) begin
            tick();
            if (o_hash_en == 2'b01) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("[TB] FAIL midrst_start: got no start expected 01 within 64 cycles"); end
        tick();
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        checks++; if (o_gnt !== 4'b0000 || o_done !== 4'b0000 || o_err !== 1'b0 || o_hash_en !== 2'b00) begin failures++; $display("[TB] FAIL midrst_ctrl: got gnt=%b done=%b err=%b en=%b expected all 0", o_gnt, o_done, o_err, o_hash_en); end
        checks++; if (o_hash_mode !== 2'b00 || o_hash_in !== 272'd0 || o_out !== 1344'd0) begin failures++; $display("[TB] FAIL midrst_data: got mode=%b in low %h out low %h expected 0", o_hash_mode, o_hash_in[63:0], o_out[63:0]); end
        i_rst = 1'b0;
        serveJob(6, dR, 1'b0, jStarted, jWait, jGnt, jZeros, jModeStart, jModeStable, jModeAck, jInAck, jEnAck, jDoneAck, jOutAck);
        checks++; if (jWait != 1 || jGnt !== 4'b1000) begin failures++; $display("[TB] FAIL midrst_restart: got wait=%0d gnt=%b expected 1 1000", jWait, jGnt); end
        checks++; if (jDoneAck !== 4'b1000 || jOutAck !== dR) begin failures++; $display("[TB] FAIL midrst_done: got done=%b out low %h expected 1000 %h", jDoneAck, jOutAck[63:0], dR[63:0]); end
        i_req = 4'b0000;
        tick();
        lastDigest = dR;
    endtask

    task automatic test_timeout;
        bit            seen;
        bit            errSeen;
        bit            sawDone;
        int            ticks;
        logic [1:0]    enAtErr;
        logic [1343:0] dT;
        seen    = 1'b0;
        errSeen = 1'b0;
        sawDone = 1'b0;
        ticks   = 0;
        enAtErr = '0;
        dT      = mkDigest(64'h7777);
        i_req   = 4'b0011;
        for (int t = 0; t < 64 && !seen; t++) begin
            tick();
            if (o_hash_en == 2'b01) seen = 1'b1;
        end
        checks++; if (!seen || o_gnt !== 4'b0001) begin failures++; $display("[TB] FAIL tmo_start: got start=%0d gnt=%b expected 1 0001", seen, o_gnt); end
        for (int t = 0; t < 40 && !errSeen; t++) begin
            tick();
            ticks++;
            if (o_done !== 4'b0000) sawDone = 1'b1;
            if (o_err === 1'b1) begin
                errSeen = 1'b1;
                enAtErr = o_hash_en;
            end
        end
`ifdef HASH_ARB_TIMEOUT_EN
        checks++; if (!errSeen || ticks != 17) begin failures++; $display("[TB] FAIL tmo_err_time: got seen=%0d after %0d cycles expected 1 after 17", errSeen, ticks); end
        checks++; if (enAtErr !== 2'b10 || sawDone) begin failures++; $display("[TB] FAIL tmo_ack: got en=%b done_seen=%0d expected 10 0", enAtErr, sawDone); end
        checks++; if (o_out !== lastDigest) begin failures++; $display("[TB] FAIL tmo_out_hold: got low %h expected %h", o_out[127:0], lastDigest[127:0]); end
        i_req = 4'b0010;
        tick();
        checks++; if (o_err !== 1'b0) begin failures++; $display("[TB] FAIL tmo_err_width: got %b expected 0", o_err); end
`else
        checks++; if (errSeen || sawDone || o_hash_en !== 2'b00 || o_gnt !== 4'b0001) begin failures++; $display("[TB] FAIL notmo_wait: got err=%0d done=%0d en=%b gnt=%b expected 0 0 00 0001", errSeen, sawDone, o_hash_en, o_gnt); end
        i_hash_done = 1'b1;
        i_hash_out  = dT;
        tick();
        i_hash_done = 1'b0;
        i_hash_out  = '0;
        checks++; if (o_done !== 4'b0001 || o_err !== 1'b0) begin failures++; $display("[TB] FAIL notmo_done: got done=%b err=%b expected 0001 0", o_done, o_err); end
        i_req = 4'b0010;
        tick();
`endif
        serveJob(5, dT, 1'b0, jStarted, jWait, jGnt, jZeros, jModeStart, jModeStable, jModeAck, jInAck, jEnAck, jDoneAck, jOutAck);
        checks++; if (jGnt !== 4'b0010 || jDoneAck !== 4'b0010) begin failures++; $display("[TB] FAIL tmo_next_gnt: got gnt=%b done=%b expected 0010", jGnt, jDoneAck); end
        i_req = 4'b0000;
        tick();
    endtask

    // Test sequence
    initial begin
        i_rst       = 1'b1;
        i_req       = '0;
        i_mode      = '0;
        i_hash_done = 1'b0;
        i_hash_out  = '0;
        lastDigest  = '0;
        for (int k = 0; k < NREQ; k++) begin
            i_in[272*k +: 272] = {17{16'(16'h1357 * (k + 3))}};
        end
        test_reset();
        test_single_job();
        test_fairness();
        test_input_stability();
        test_back_to_back();
        test_reset_mid_job();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of sequence expected finish before 2 ms");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
